pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall counter width.
REQ-003 The block SHALL have parameter ZERO_ON_FLUSH, default 0; when set to 1, a flush also zeroes the data registers.
REQ-004 The block SHALL have input clk, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The block SHALL have input rstn, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have input flush, 1 bit: synchronous pipeline kill.
REQ-007 The block SHALL have input in_valid, 1 bit: upstream offers a beat.
REQ-008 The block SHALL have output in_ready, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have input in_data, DATA_W bits: upstream payload.
REQ-010 The block SHALL have output out_valid, 1 bit: a beat is presented downstream.
REQ-011 The block SHALL have input out_ready, 1 bit: downstream accepts.
REQ-012 The block SHALL have output out_data, DATA_W bits: registered payload.
REQ-013 The block SHALL have output stall_cnt, CNT_W bits: count of back-pressure cycles.

Function
REQ-014 A beat SHALL transfer in when in_valid and in_ready are both 1, and SHALL transfer out when out_valid and out_ready are both 1.
REQ-015 Beats SHALL leave in acceptance order, with none dropped or duplicated except by flush.
REQ-016 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_valid/out_data after edge N when the output register is empty.
REQ-017 out_data SHALL hold stable while out_valid is 1 and out_ready is 0.
REQ-018 Sustained throughput SHALL be 1 beat per cycle while out_ready stays 1.
REQ-019 Without skid, in_ready SHALL be (out_ready OR NOT out_valid), combinational.
REQ-020 Without skid, on a simultaneous in-transfer and out-transfer the output register SHALL load the new beat and out_valid SHALL stay 1.
REQ-021 flush=1 at an edge SHALL clear out_valid and all internal valid state.
REQ-022 A beat offered in the flush cycle SHALL be discarded.
REQ-023 Flush SHALL take priority over any simultaneous transfer.
REQ-024 On flush, data registers SHALL hold their value if ZERO_ON_FLUSH=0 and SHALL be zeroed if ZERO_ON_FLUSH=1.
REQ-025 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0.
REQ-026 stall_cnt SHALL saturate at all-ones and never wrap.
REQ-027 stall_cnt SHALL be unaffected by flush.

Reset
REQ-028 While rstn=0 at an edge, out_valid, skid valid and stall_cnt SHALL be set to 0 and out_data SHALL be set to 0.
REQ-029 in_ready SHALL be 0 while rstn=0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.
REQ-031 A reset asserted mid-stream SHALL discard all held beats, and nothing SHALL be emitted from them afterwards.

Configuration
REQ-032 Macro PIPE_STAGE_SKID_EN SHALL select the skid-buffer variant.
REQ-033 With PIPE_STAGE_SKID_EN defined, the block SHALL add a one-entry skid register.
REQ-034 With PIPE_STAGE_SKID_EN defined, in_ready SHALL be a flop output equal to NOT skid_valid, with no combinational path from out_ready.
REQ-035 With PIPE_STAGE_SKID_EN defined, a beat accepted while the output is stalled SHALL go to the skid register.
REQ-036 With PIPE_STAGE_SKID_EN defined, the skid beat SHALL move to the output on the next out-transfer.
REQ-037 With PIPE_STAGE_SKID_EN defined, throughput SHALL be 1 beat per cycle with no bubbles.
REQ-038 With PIPE_STAGE_SKID_EN defined, at most 2 beats SHALL be in flight.
REQ-039 Without PIPE_STAGE_SKID_EN, the block SHALL be a single register stage per REQ-019 and REQ-020, with at most 1 beat in flight.

Structure
REQ-040 Package pipe_pkg SHALL hold the default DATA_W and CNT_W constants and the payload struct typedef that MEM/WB-style stages instantiate as DATA_W.
REQ-041 The saturating counter SHALL be sub-module pipe_sat_ctr, parameterised by CNT_W, with inputs inc and rstn.
REQ-042 No other sub-modules SHALL be used.

Verification
REQ-043 Reset, then in_valid=1 with in_data=0xA5A5_0001 and out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5_0001, stall_cnt=0.
REQ-044 Stream 0x1..0x8 with out_ready held low for cycles 3-5 -> output sequence exactly 0x1..0x8, stall_cnt=3, and in the skid build in_ready=0 by cycle 4.
REQ-045 Stream with out_ready=1 continuously, both builds -> 8 beats in 8 consecutive cycles with no bubble.
REQ-046 Two beats held (skid build), then flush=1 while in_valid=1 with 0xDEAD -> next cycle out_valid=0, 0xDEAD never emitted, and out_data=0 when ZERO_ON_FLUSH=1.
REQ-047 CNT_W=4 with out_ready held 0 for 20 cycles while valid -> stall_cnt=0xF, no wrap.
REQ-048 rstn=0 with 2 beats held -> after release out_valid=0, in_ready=1, and no stale beat is emitted.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and payload typedef for single-register pipeline stages.
// Optional skid variant is selected by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  // MEM/WB-style stages carry this payload through a DATA_W-wide buffer
  typedef struct packed {
    logic                  vld;
    logic [DEF_DATA_W-1:0] data;
  } pipePayload_t;
endpackage

// File: rtl/pipe_stage_buf_sat_ctr.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, sync active-low reset.
module pipe_sat_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rstn)                 cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the skid-buffer variant (registered in_ready).
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ZERO_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              outValidQ;
  logic [DATA_W-1:0] outDataQ;
  logic              inFire;

  assign inFire    = in_valid & in_ready;
  assign out_valid = outValidQ;
  assign out_data  = outDataQ;

`ifdef PIPE_STAGE_SKID_EN
  logic              skidValid;
  logic [DATA_W-1:0] skidData;

  // Ready depends only on state; rstn gating keeps it low through reset
  assign in_ready = rstn & ~skidValid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
    end else if (flush) begin
      outValidQ <= 1'b0;
      skidValid <= 1'b0;
      if (ZERO_ON_FLUSH != 0) begin
        outDataQ <= '0;
        skidData <= '0;
      end
    end else if (!outValidQ || out_ready) begin
      // Output slot frees up: the skid beat is older than anything offered now
      if (skidValid) begin
        outDataQ  <= skidData;
        outValidQ <= 1'b1;
        skidValid <= 1'b0;
      end else begin
        outValidQ <= inFire;
        if (inFire) outDataQ <= in_data;
      end
    end else if (inFire) begin
      skidValid <= 1'b1;
      skidData  <= in_data;
    end
  end
`else
  assign in_ready = rstn & (out_ready | ~outValidQ);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else if (flush) begin
      outValidQ <= 1'b0;
      if (ZERO_ON_FLUSH != 0) outDataQ <= '0;
    end else if (inFire) begin
      outValidQ <= 1'b1;
      outDataQ  <= in_data;
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end
`endif

  pipe_sat_ctr #(.CNT_W(CNT_W)) uStallCtr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (outValidQ & ~out_ready),
    .cnt  (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: accepted beats queue up, a monitor pops and compares on output transfers.
module tb_pipe_stage_buf;
  logic        clk = 1'b0;
  logic        rstn = 1'b0, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
  logic [31:0] inData = '0;
  logic        inReady, outValid, inReady0, outValid0;
  logic [31:0] outData, outData0;
  logic [3:0]  stallCnt;
  logic [15:0] stallCnt0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CNT_W(4), .ZERO_ON_FLUSH(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .in_data(inData), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .stall_cnt(stallCnt));

  pipe_stage_buf dut0 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(inValid), .in_ready(inReady0),
    .in_data(inData), .out_valid(outValid0), .out_ready(outReady), .out_data(outData0),
    .stall_cnt(stallCnt0));

  int          nTests = 0, nFail = 0;
  logic [31:0] q[$];
  logic [31:0] outLog[$];
  int          sc = 0, popCnt = 0;
  logic [31:0] last1 = '0, last0 = '0;
  bit          flushedEmpty = 1'b1, armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare presented state to the model, then apply the upcoming edge
  always @(negedge clk) begin
    if (armed) begin
      int sz;
      bit expRdy;
      sz = q.size();
`ifdef PIPE_STAGE_SKID_EN
      expRdy = rstn && (sz < 2);
`else
      expRdy = rstn && (outReady || sz == 0);
`endif
      chk("in_ready", inReady, expRdy);
      chk("in_ready0", inReady0, expRdy);
      chk("out_valid", outValid, sz > 0);
      chk("out_valid0", outValid0, sz > 0);
      if (sz > 0) begin
        chk("out_data", outData, q[0]);
        chk("out_data0", outData0, q[0]);
        last0 = q[0];
        last1 = q[0];
      end else if (flushedEmpty) begin
        chk("idle_data_zero", outData, last1);
        chk("idle_data_hold", outData0, last0);
      end
      chk("stall_cnt", stallCnt, (sc > 15) ? 15 : sc);
      chk("stall_cnt0", stallCnt0, (sc > 65535) ? 65535 : sc);
      if (!rstn) begin
        q.delete();
        sc = 0; last0 = '0; last1 = '0; flushedEmpty = 1'b1;
      end else begin
        if (sz > 0 && !outReady) sc++;
        if (flush) begin
          q.delete();
          last1 = '0;
          flushedEmpty = 1'b1;
        end else if (sz > 0 && outReady) begin
          outLog.push_back(q.pop_front());
          popCnt++;
        end
      end
    end
  end

  // Acceptance recorder runs after the monitor has applied pops/flushes
  always @(negedge clk) begin
    #2;
    if (armed && rstn && !flush && inValid && inReady) begin
      q.push_back(inData);
      flushedEmpty = 1'b0;
    end
  end

  task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] d, input bit ordy);
    @(posedge clk); #1;
    rstn = r; flush = f; inValid = v; inData = d; outReady = ordy;
  endtask

  task automatic smp();
    @(negedge clk); #3;
  endtask

  task automatic doReset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1);
  endtask

  // Offer beats 1..n in order, holding each until accepted; out_ready low for cycles sFrom..sTo
  task automatic stream(input int n, input int sFrom, input int sTo, output int cycles, output bit rdyAt4);
    int idx = 1;
    int c = 0;
    rdyAt4 = 1'b1;
    while (idx <= n && c < 60) begin
      c++;
      cyc(1, 0, 1, 32'(idx), !(c >= sFrom && c <= sTo));
      smp();
      if (c == 4) rdyAt4 = inReady;
      if (inReady) idx++;
    end
    cycles = c;
    if (idx <= n) chk("stream_timeout", 64'(idx), 64'(n + 1));
  endtask

  initial begin
    int  cycles, p0;
    bit  r4, sawDead;
    @(posedge clk); #1;
    armed = 1'b1;
    doReset();

    // Single beat, one-cycle latency
    cyc(1, 0, 1, 32'hA5A5_0001, 1);
    cyc(1, 0, 0, 0, 1);
    smp();
    chk("lat_valid", outValid, 1);
    chk("lat_data", outData, 32'hA5A5_0001);
    chk("lat_stall", stallCnt, 0);
    drain(3);

    // Stream with back-pressure in cycles 3..5
    doReset();
    outLog.delete();
    stream(8, 3, 5, cycles, r4);
    chk("bp_ready_c4", r4, 0);
    drain(6);
    chk("bp_count", 64'(outLog.size()), 8);
    for (int i = 0; i < outLog.size() && i < 8; i++) chk("bp_order", outLog[i], 32'(i + 1));
    chk("bp_stall", stallCnt0, 3);

    // Full-rate stream
    p0 = popCnt;
    stream(8, 0, -1, cycles, r4);
    chk("rate_accept_cycles", 64'(cycles), 8);
    cyc(1, 0, 0, 0, 1);
    smp();
    chk("rate_pops", 64'(popCnt - p0), 8);
    drain(3);

    // Flush with two beats held and a beat offered in the flush cycle
    outLog.delete();
    cyc(1, 0, 1, 32'h0000_0A0A, 0);
    cyc(1, 0, 1, 32'h0000_0B0B, 0);
    cyc(1, 1, 1, 32'h0000_DEAD, 0);
    cyc(1, 0, 0, 0, 1);
    smp();
    chk("flush_valid", outValid, 0);
    chk("flush_zero", outData, 0);
    drain(4);
    sawDead = 1'b0;
    foreach (outLog[i]) if (outLog[i] == 32'hDEAD) sawDead = 1'b1;
    chk("flush_no_dead", sawDead, 0);

    // Saturation of the 4-bit counter
    doReset();
    cyc(1, 0, 1, 32'h1234, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0);
    smp();
    chk("sat_cnt4", stallCnt, 4'hF);
    drain(3);

    // Reset mid-stream with two beats held
    cyc(1, 0, 1, 32'h1111, 0);
    cyc(1, 0, 1, 32'h2222, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    smp();
    chk("rst_valid", outValid, 0);
    chk("rst_ready", inReady, 1);
    p0 = popCnt;
    drain(5);
    chk("rst_no_stale", 64'(popCnt - p0), 0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
          $urandom, $urandom_range(0, 9) < 7);
    drain(4);
    smp();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
